// File: rtl/h80_uart_tx_arbiter_if.sv
// Byte-stream requester bus plus UART transmitter handshake shared by h80_uart_tx_arbiter.
// Requesters: byte i moves when req_valid[i] && req_ready[i] on a clock edge; ready is combinational
// and one-hot, and valid may drop at any time without losing a byte. UART: tx_en holds tx_data
// until tx_busy is sampled high, and the next byte waits until tx_busy is sampled low again.
interface h80_uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_en;
  logic                 tx_busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_en
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_en
  );
endinterface

// File: rtl/h80_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional H80_UART_ARB_STATS_EN adds per-requester captured-byte counters on byte_cnt.
module h80_uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ACK_TIMEOUT  = 255,
  parameter int LOCK_TIMEOUT = 4095
) (
  input  logic                    clk,
  input  logic                    reset_n,
  h80_uart_tx_arbiter_if.slave    bus,
  output logic [1:0]              grant_id,
  output logic                    locked,
  output logic                    ack_err,
  output logic [1:0]              dbg_state
`ifdef H80_UART_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]   byte_cnt
`endif
);

  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACK  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_tx_data, w_tx_data_nxt;
  logic                r_tx_en, w_tx_en_nxt;
  logic [1:0]          r_grant, w_grant_nxt;
  logic                r_locked, w_locked_nxt;
  logic                r_ack_err, w_ack_err_nxt;
  logic [ACK_W-1:0]    r_ack_cnt, w_ack_cnt_nxt, w_ack_inc;
  logic [LOCK_W-1:0]   r_stall_cnt, w_stall_cnt_nxt;

  logic [3:0]          w_valid4, w_last4, w_ready4;
  logic [31:0]         w_data4;
  logic [1:0]          w_pick, w_idx;
  logic                w_pick_valid;
  logic                w_capture;

  // Widen the request bus to four lanes so a 2-bit grant can index it directly.
  always_comb begin
    w_valid4 = '0;
    w_last4  = '0;
    w_data4  = '0;
    w_valid4[NUM_REQ-1:0]   = bus.req_valid;
    w_last4[NUM_REQ-1:0]    = bus.req_last;
    w_data4[8*NUM_REQ-1:0]  = bus.req_data;
  end

  // Locked: only the holder may send. Unlocked: nearest valid requester after the last grant.
  always_comb begin
    w_pick       = r_grant;
    w_pick_valid = 1'b0;
    w_idx        = r_grant;
    if (r_locked) begin
      w_pick_valid = w_valid4[r_grant];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        w_idx = 2'((int'(r_grant) + k) % NUM_REQ);
        if (w_valid4[w_idx]) begin
          w_pick       = w_idx;
          w_pick_valid = 1'b1;
        end
      end
    end
  end

  assign w_ack_inc = (r_ack_cnt == ACK_W'(ACK_TIMEOUT)) ? r_ack_cnt : r_ack_cnt + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_data_nxt   = r_tx_data;
    w_tx_en_nxt     = r_tx_en;
    w_grant_nxt     = r_grant;
    w_locked_nxt    = r_locked;
    w_ack_err_nxt   = r_ack_err;
    w_ack_cnt_nxt   = r_ack_cnt;
    w_stall_cnt_nxt = r_stall_cnt;
    w_ready4        = '0;
    w_capture       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.tx_busy && w_pick_valid) begin
          w_capture          = 1'b1;
          w_ready4[w_pick]   = 1'b1;
          w_tx_data_nxt      = w_data4[{w_pick, 3'b000} +: 8];
          w_tx_en_nxt        = 1'b1;
          w_grant_nxt        = w_pick;
          w_locked_nxt       = ~w_last4[w_pick];
          w_ack_cnt_nxt      = '0;
          w_stall_cnt_nxt    = '0;
          w_state_nxt        = S_WAIT_ACK;
        end else if (r_locked && !w_valid4[r_grant]) begin
          if (r_stall_cnt != LOCK_W'(LOCK_TIMEOUT)) begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
          end
          if (w_stall_cnt_nxt == LOCK_W'(LOCK_TIMEOUT)) begin
            w_locked_nxt = 1'b0;
          end
        end
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) begin
          w_tx_en_nxt = 1'b0;
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_ack_cnt_nxt = w_ack_inc;
          // The UART never answered: drop the byte and free the link for others.
          if (w_ack_inc == ACK_W'(ACK_TIMEOUT)) begin
            w_tx_en_nxt   = 1'b0;
            w_ack_err_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tx_data   <= '0;
      r_tx_en     <= 1'b0;
      r_grant     <= 2'(NUM_REQ - 1);
      r_locked    <= 1'b0;
      r_ack_err   <= 1'b0;
      r_ack_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_en     <= w_tx_en_nxt;
      r_grant     <= w_grant_nxt;
      r_locked    <= w_locked_nxt;
      r_ack_err   <= w_ack_err_nxt;
      r_ack_cnt   <= w_ack_cnt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign bus.req_ready = w_ready4[NUM_REQ-1:0];
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_en     = r_tx_en;
  assign grant_id      = r_grant;
  assign locked        = r_locked;
  assign ack_err       = r_ack_err;
  assign dbg_state     = r_state;

`ifdef H80_UART_ARB_STATS_EN
  logic [15:0] r_byte_cnt [NUM_REQ];

  // Counted at capture, so bytes later dropped on an ack timeout are included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_byte_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_capture && (w_pick == 2'(i)) && (r_byte_cnt[i] != 16'hFFFF)) begin
          r_byte_cnt[i] <= r_byte_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign byte_cnt[16*g +: 16] = r_byte_cnt[g];
  end
`endif

endmodule

// File: tb/tb_h80_uart_tx_arbiter.sv
// Self-checking bench for h80_uart_tx_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin model.
module tb_h80_uart_tx_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ACK_TO  = 8;
  localparam int LOCK_TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  h80_uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();
  logic [1:0] grant_id, dbg_state;
  logic       locked, ack_err;
`ifdef H80_UART_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] byte_cnt;
`endif

  h80_uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TO), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .grant_id(grant_id), .locked(locked), .ack_err(ack_err), .dbg_state(dbg_state)
`ifdef H80_UART_ARB_STATS_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [8:0] src_mem [NUM_REQ][64];
  int         src_wr [NUM_REQ];
  int         src_rd [NUM_REQ];
  int         gap    [NUM_REQ];
  bit         uart_auto = 1'b0;
  logic       man_busy  = 1'b0;
  logic       uart_busy = 1'b0;

  assign bus.tx_busy = uart_auto ? uart_busy : man_busy;

  // ---------------- requester driver ----------------
  initial begin
    logic [NUM_REQ-1:0]   taken, v, l;
    logic [8*NUM_REQ-1:0] d;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; gap[i] = 0;
    end
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    forever begin
      @(negedge clk);
      taken = bus.req_ready;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (taken[i] && src_rd[i] < src_wr[i]) begin
          if (!src_mem[i][src_rd[i]][8]) gap[i] = $urandom_range(0, 3);
          src_rd[i]++;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
        if (src_rd[i] < src_wr[i] && gap[i] == 0) begin
          v[i]        = 1'b1;
          d[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
          l[i]        = src_mem[i][src_rd[i]][8];
        end
      end
      bus.req_valid = v; bus.req_data = d; bus.req_last = l;
    end
  end

  // ---------------- UART responder (auto mode) ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (uart_auto && bus.tx_en) begin
        obs_q.push_back({grant_id, bus.tx_data});
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    uart_auto = 1'b0;
    man_busy  = 1'b0;
    reset_n   = 1'b0;
    repeat (12) @(posedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; gap[i] = 0;
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic enqueue(input int r, input logic last, input logic [7:0] data);
    src_mem[r][src_wr[r]] = {last, data};
    src_wr[r]++;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx_en(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.tx_en, bus.tx_data, grant_id, locked, ack_err} !== {1'b0, 8'h00, 2'(NUM_REQ-1), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got en=%0b data=%h gid=%0d lk=%0b err=%0b, want 0 00 %0d 0 0",
               bus.tx_en, bus.tx_data, grant_id, locked, ack_err, NUM_REQ-1);
    end
    n_cmp++;
    if (bus.req_ready !== '0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
    end
`ifdef H80_UART_ARB_STATS_EN
    n_cmp++;
    if (byte_cnt !== '0) begin
      n_err++; $display("FAIL reset_byte_cnt: got %h want 0", byte_cnt);
    end
`endif
  endtask

  task automatic test_single_byte();
    bit ok;
    do_reset();
    enqueue(0, 1'b1, 8'h41);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || bus.req_ready !== 3'b001) begin
      n_err++; $display("FAIL single_ready: got %b want 001", bus.req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.tx_en, bus.tx_data, grant_id, locked, bus.req_ready} !== {1'b1, 8'h41, 2'd0, 1'b0, 3'b000}) begin
      n_err++;
      $display("FAIL single_tx: got en=%0b data=%h gid=%0d lk=%0b rdy=%b, want 1 41 0 0 000",
               bus.tx_en, bus.tx_data, grant_id, locked, bus.req_ready);
    end
    @(posedge clk); #1 man_busy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.tx_en !== 1'b1) begin
      n_err++; $display("FAIL single_hold: tx_en got %0b want 1", bus.tx_en);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.tx_en !== 1'b0) begin
      n_err++; $display("FAIL single_drop: tx_en got %0b want 0", bus.tx_en);
    end
    @(posedge clk); #1 man_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.tx_en, bus.req_ready} !== 4'b0000) begin
      n_err++; $display("FAIL single_idle: got en=%0b rdy=%b want 0 000", bus.tx_en, bus.req_ready);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [9:0] o, e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      enqueue(0, 1'b1, 8'h10 + 8'(k));
      enqueue(1, 1'b1, 8'h20 + 8'(k));
      exp_q.push_back({2'd0, 8'h10 + 8'(k)});
      exp_q.push_back({2'd1, 8'h20 + 8'(k)});
    end
    uart_auto = 1'b1;
    wait_obs(8, 400, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL rr_timeout: got %0d bytes want 8", obs_q.size());
    end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL rr_order: got id=%0d data=%h want id=%0d data=%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    logic [9:0] o, e;
    do_reset();
    enqueue(0, 1'b0, 8'hA0); enqueue(0, 1'b0, 8'hA1); enqueue(0, 1'b1, 8'hA2);
    enqueue(1, 1'b1, 8'hB0);
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'hA1});
    exp_q.push_back({2'd0, 8'hA2}); exp_q.push_back({2'd1, 8'hB0});
    uart_auto = 1'b1;
    wait_obs(4, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL lock_timeout_wait: got %0d bytes want 4", obs_q.size());
    end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL lock_order: got id=%0d data=%h want id=%0d data=%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
  endtask

  task automatic test_lock_timeout();
    bit ok, found;
    int n;
    do_reset();
    enqueue(0, 1'b0, 8'h55);
    enqueue(1, 1'b1, 8'h66);
    wait_tx_en(20, ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd0 || locked !== 1'b1) begin
      n_err++; $display("FAIL lto_first: got ok=%0b gid=%0d lk=%0b want 1 0 1", ok, grant_id, locked);
    end
    @(posedge clk); #1 man_busy = 1'b1;
    @(posedge clk); #1 man_busy = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready[1]) begin found = 1'b1; break; end
      n++;
    end
    // One WAIT_DONE cycle, then LOCK_TO locked idle cycles, before requester 1 is taken.
    n_cmp++;
    if (!found || n != LOCK_TO + 1) begin
      n_err++; $display("FAIL lto_cycles: got found=%0b cycles=%0d want 1 %0d", found, n, LOCK_TO + 1);
    end
    n_cmp++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL lto_unlocked: locked got %0b want 0", locked);
    end
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int n;
    do_reset();
    enqueue(1, 1'b0, 8'h77);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready[1]) begin ok = 1'b1; break; end
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.tx_en) n++;
      else break;
    end
    n_cmp++;
    if (!ok || n != ACK_TO) begin
      n_err++; $display("FAIL ack_to_cycles: got ok=%0b en_cycles=%0d want 1 %0d", ok, n, ACK_TO);
    end
    n_cmp++;
    if ({ack_err, locked} !== 2'b10) begin
      n_err++; $display("FAIL ack_to_flags: got err=%0b lk=%0b want 1 0", ack_err, locked);
    end
    enqueue(0, 1'b1, 8'h12);
    wait_tx_en(20, ok);
    @(posedge clk); #1 man_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 man_busy = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || ack_err !== 1'b1 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL ack_err_sticky: got ok=%0b err=%0b gid=%0d want 1 1 0", ok, ack_err, grant_id);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, saw_en;
    do_reset();
    enqueue(0, 1'b0, 8'h99);
    wait_tx_en(20, ok);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || {bus.tx_en, locked, grant_id, bus.tx_data} !== {1'b0, 1'b0, 2'(NUM_REQ-1), 8'h00}) begin
      n_err++;
      $display("FAIL reset_mid: got ok=%0b en=%0b lk=%0b gid=%0d data=%h want 1 0 0 %0d 00",
               ok, bus.tx_en, locked, grant_id, bus.tx_data, NUM_REQ-1);
    end
`ifdef H80_UART_ARB_STATS_EN
    n_cmp++;
    if (byte_cnt !== '0) begin
      n_err++; $display("FAIL reset_mid_cnt: got %h want 0", byte_cnt);
    end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw_en = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.tx_en) saw_en = 1'b1;
    end
    n_cmp++;
    if (saw_en !== 1'b0) begin
      n_err++; $display("FAIL reset_no_resend: saw tx_en=%0b want 0", saw_en);
    end
  endtask

  task automatic test_random();
    bit ok;
    int npk [NUM_REQ];
    int plen [NUM_REQ][4];
    logic [7:0] bytes [NUM_REQ][16];
    int pos [NUM_REQ], done [NUM_REQ], cnt [NUM_REQ];
    int p, total, r;
    logic [9:0] o, e;
    do_reset();
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      npk[i] = $urandom_range(1, 3); pos[i] = 0; done[i] = 0; cnt[i] = 0;
      for (int k = 0; k < npk[i]; k++) begin
        plen[i][k] = $urandom_range(1, 4);
        for (int b = 0; b < plen[i][k]; b++) begin
          bytes[i][cnt[i]] = 8'($urandom_range(0, 255));
          enqueue(i, (b == plen[i][k] - 1), bytes[i][cnt[i]]);
          cnt[i]++; total++;
        end
      end
    end
    // Every requester stays backlogged, so service is whole packets in round-robin order.
    p = 0;
    for (int t = 0; t < 3 * NUM_REQ; t++) begin
      r = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (r < 0 && done[(p + k) % NUM_REQ] < npk[(p + k) % NUM_REQ]) r = (p + k) % NUM_REQ;
      end
      if (r >= 0) begin
        for (int b = 0; b < plen[r][done[r]]; b++) begin
          exp_q.push_back({2'(r), bytes[r][pos[r]]});
          pos[r]++;
        end
        done[r]++;
        p = (r + 1) % NUM_REQ;
      end
    end
    uart_auto = 1'b1;
    wait_obs(total, 3000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL rand_timeout: got %0d bytes want %0d", obs_q.size(), total);
    end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL rand_byte: got id=%0d data=%h want id=%0d data=%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if ({ack_err, locked} !== 2'b00) begin
      n_err++; $display("FAIL rand_flags: got err=%0b lk=%0b want 0 0", ack_err, locked);
    end
`ifdef H80_UART_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      n_cmp++;
      if (byte_cnt[16*i +: 16] !== 16'(cnt[i])) begin
        n_err++; $display("FAIL rand_byte_cnt%0d: got %0d want %0d", i, byte_cnt[16*i +: 16], cnt[i]);
      end
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_lock_timeout();
    test_ack_timeout();
    test_reset_mid();
    for (int k = 0; k < 4; k++) test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
